readout_frame_builder: RTL and testbench

Downstream stage of the readout FIFO FSM: once the FSM selects a full channel FIFO and starts draining it, this block wraps the drained words into a frame. Each frame is a header word (channel, sequence number), the payload words, and a trailer word (word count, truncation flag). Frames leave on a valid/ready stream toward the link serializer. Payloads longer than MAX_WORDS are truncated: surplus words are drained and discarded.

---
 rtl/readout_frame_builder.sv | 135 +++++++++++++
 tb/tb_readout_frame_builder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/readout_frame_builder.sv
// Wraps words drained from a channel FIFO into header/payload/trailer frames.
// Payload passes through combinationally; over-length payloads are truncated.
module readout_frame_builder #(
    parameter int DATA_W    = 16,
    parameter int N_CH      = 5,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_start_i,
    input  logic [2:0]        ch_sel_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN,
        TRAILER
    } state_t;

    localparam logic [3:0] NCH_L    = 4'(N_CH);
    localparam logic [7:0] LAST_CNT = 8'(MAX_WORDS - 1);

    state_t     state_q, state_d;
    logic [2:0] ch_q, ch_d;
    logic [7:0] seq_q, seq_d;
    logic [7:0] cnt_q, cnt_d;
    logic       trunc_q, trunc_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic       ch_ok;

    assign ch_ok        = {1'b0, ch_sel_i} < NCH_L;
    assign busy_o       = state_q != IDLE;
    assign frame_done_o = done_q;
    assign err_o        = err_q;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        seq_d       = seq_q;
        cnt_d       = cnt_q;
        trunc_d     = trunc_q;
        err_d       = err_q;
        done_d      = 1'b0;
        out_valid_o = 1'b0;
        in_ready_o  = 1'b0;
        out_data_o  = '0;

        // A start is only legal from IDLE and for an existing channel
        if (rd_start_i && (state_q != IDLE || !ch_ok)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (rd_start_i && ch_ok) begin
                    ch_d    = ch_sel_i;
                    cnt_d   = 8'd0;
                    trunc_d = 1'b0;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                out_valid_o       = 1'b1;
                out_data_o[15:0]  = {4'hA, 1'b0, ch_q, seq_q};
                if (out_ready_i) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                out_valid_o = in_valid_i;
                out_data_o  = in_data_i;
                in_ready_o  = out_ready_i;
                if (in_valid_i && out_ready_i) begin
                    cnt_d = 8'(cnt_q + 8'd1);
                    if (in_last_i) begin
                        state_d = TRAILER;
                    end else if (cnt_q == LAST_CNT) begin
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                in_ready_o = 1'b1;
                if (in_valid_i && in_last_i) begin
                    state_d = TRAILER;
                end
            end
            TRAILER: begin
                out_valid_o      = 1'b1;
                out_data_o[15:0] = {4'hE, trunc_q, 3'b000, cnt_q};
                if (out_ready_i) begin
                    seq_d   = 8'(seq_q + 8'd1);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= 3'd0;
            seq_q   <= 8'd0;
            cnt_q   <= 8'd0;
            trunc_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_readout_frame_builder.sv
// Directed bench for readout_frame_builder (MAX_WORDS=4 so truncation is reachable).
// Output handshakes are collected at the falling edge and compared to hand-built frames.
module tb_readout_frame_builder;

    logic        clk;
    logic        reset;
    logic        rd_start_i;
    logic [2:0]  ch_sel_i;
    logic [15:0] in_data_i;
    logic        in_valid_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic [15:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        busy_o;
    logic        frame_done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [15:0] out_q[$];
    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [15:0] held = '0;

    readout_frame_builder #(
        .DATA_W(16),
        .N_CH(5),
        .MAX_WORDS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_start_i(rd_start_i),
        .ch_sel_i(ch_sel_i),
        .in_data_i(in_data_i),
        .in_valid_i(in_valid_i),
        .in_last_i(in_last_i),
        .in_ready_o(in_ready_o),
        .out_data_o(out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Output monitor: collects handshakes, checks stall stability
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid_o) chk("stall_data", out_data_o, held);
            if (out_valid_o && out_ready_i) out_q.push_back(out_data_o);
            stalled = out_valid_o && !out_ready_i;
            held = out_data_o;
            if (stalled) chk("stall_irdy", in_ready_o, 0);
            if (frame_done_o) begin
                done_cnt++;
                chk("done_busy", busy_o, 0);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_frame(input logic [2:0] ch, input bit bp,
                             input int inject_at, input int abort_at);
        int  idx;
        bit  tog;
        bit  fin;
        bit  inj;
        bit  hs;
        bit  dn;
        int  n;
        n = src_q.size();
        out_q.delete();
        idx = 0; tog = 1'b1; fin = 1'b0; inj = 1'b0;
        rd_start_i = 1'b1;
        ch_sel_i = ch;
        @(posedge clk); #1;
        rd_start_i = 1'b0;
        ch_sel_i = 3'd0;
        for (int c = 0; c < 300; c++) begin
            if (abort_at >= 0 && idx == abort_at) begin
                in_valid_i = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy_o, 0);
                chk("abort_ovalid", out_valid_o, 0);
                @(posedge clk); #1;
                fin = 1'b1;
                break;
            end
            out_ready_i = bp ? tog : 1'b1;
            tog = !tog;
            in_valid_i = idx < n;
            in_data_i = (idx < n) ? src_q[idx] : 16'h0;
            in_last_i = (idx == n - 1);
            rd_start_i = (idx == inject_at) && !inj;
            ch_sel_i = 3'd4;
            if (rd_start_i) inj = 1'b1;
            @(negedge clk);
            hs = in_valid_i && in_ready_o;
            dn = frame_done_o;
            @(posedge clk); #1;
            if (hs) idx++;
            if (dn) begin
                fin = 1'b1;
                break;
            end
        end
        rd_start_i = 1'b0;
        ch_sel_i = 3'd0;
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
        out_ready_i = 1'b1;
        if (!fin) chk("timeout", 0, 1);
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
        end
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        rd_start_i = 1'b0;
        ch_sel_i = 3'd0;
        in_data_i = '0;
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovalid", out_valid_o, 0);
        chk("rst_irdy", in_ready_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_done", frame_done_o, 0);
        @(posedge clk); #1;

        d0 = done_cnt;
        src_q = '{16'h0101, 16'h0202, 16'h0303};
        run_frame(3'd2, 1'b0, -1, -1);
        exp_q = '{16'hA200, 16'h0101, 16'h0202, 16'h0303, 16'hE003};
        cmp_frame("basic");
        chk("basic_done", done_cnt - d0, 1);
        chk("basic_err", err_o, 0);

        do_reset();
        src_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
        run_frame(3'd1, 1'b0, -1, -1);
        exp_q = '{16'hA100, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'hE804};
        cmp_frame("trunc");

        src_q = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        run_frame(3'd1, 1'b0, -1, -1);
        exp_q = '{16'hA101, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'hE004};
        cmp_frame("exact");

        do_reset();
        src_q = '{16'h1111, 16'h2222, 16'h3333};
        run_frame(3'd3, 1'b1, -1, -1);
        exp_q = '{16'hA300, 16'h1111, 16'h2222, 16'h3333, 16'hE003};
        cmp_frame("bp");

        out_q.delete();
        rd_start_i = 1'b1;
        ch_sel_i = 3'd5;
        @(posedge clk); #1;
        rd_start_i = 1'b0;
        ch_sel_i = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("badch_busy", busy_o, 0);
        chk("badch_err", err_o, 1);
        chk("badch_nout", out_q.size(), 0);
        @(posedge clk); #1;

        do_reset();
        @(negedge clk);
        chk("err_clr", err_o, 0);
        @(posedge clk); #1;
        src_q = '{16'h0AAA, 16'h0BBB, 16'h0CCC};
        run_frame(3'd2, 1'b0, 1, -1);
        exp_q = '{16'hA200, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'hE003};
        cmp_frame("inject");
        chk("inject_err", err_o, 1);

        src_q = '{16'h5555, 16'h6666, 16'h7777};
        run_frame(3'd2, 1'b0, -1, 2);
        exp_q = '{16'hA201, 16'h5555, 16'h6666};
        cmp_frame("abort");
        src_q = '{16'h00AA};
        run_frame(3'd0, 1'b0, -1, -1);
        exp_q = '{16'hA000, 16'h00AA, 16'hE001};
        cmp_frame("post_abort");

        do_reset();
        d0 = done_cnt;
        for (int i = 0; i < 257; i++) begin
            src_q = '{16'(i)};
            run_frame(3'd0, 1'b0, -1, -1);
            chk("seq_hdr", (out_q.size() > 0) ? out_q[0] : 16'hxxxx,
                {8'hA0, 8'(i)});
        end
        chk("seq_done", done_cnt - d0, 257);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
